// File: rtl/mac_chain_cfg_loader.sv
// ============================================================================
//  Module   : mac_chain_cfg_loader
//  Purpose  : Loads host configuration words into the MAC cluster scan chain.
//             Each word is shifted out LSB first with a qualifying enable.
//             The loader counts words against the chain length and pulses
//             done after the final bit.
//  Option   : CFG_LOADER_PARITY_EN adds an even-parity check on each word.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_chain_cfg_loader #(
   parameter int NUM_CLUSTERS     = 8,
   parameter int BITS_PER_CLUSTER = 64,
   parameter int WORD_W           = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              word_valid,
   input  logic [WORD_W-1:0] word_data,
   output logic              word_ready,
   output logic              config_in,
   output logic              config_en,
   output logic              busy,
   output logic              done
`ifdef CFG_LOADER_PARITY_EN
   ,
   input  logic              word_parity,
   output logic              parity_err
`endif
);

   localparam int TOTAL = NUM_CLUSTERS * BITS_PER_CLUSTER;
   localparam int WORDS = TOTAL / WORD_W;
   localparam int WCW   = $clog2(WORDS + 1);
   localparam int BCW   = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_W - 1);
   localparam logic [WCW-1:0] WORDS_C  = WCW'(WORDS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [WORD_W-1:0] shift_q, shift_d;
   logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WCW-1:0]    word_cnt_q, word_cnt_d;
   logic              config_in_q, config_en_q, busy_q, done_q;

   logic              last_bit;
   logic              more_words;
   logic              accept;
   logic              parity_ok;

`ifdef CFG_LOADER_PARITY_EN
   logic              parity_err_q;

   // A word is good when word_parity makes the total count of ones even.
   assign parity_ok  = (word_parity == ^word_data);
   assign parity_err = parity_err_q;
`else
   assign parity_ok  = 1'b1;
`endif

   // Handshake: ready in LOAD, or on the last bit of a non-final word so the
   // next word can follow without a bubble; abort always withdraws ready.
   always_comb begin
      last_bit   = (bit_cnt_q == LAST_BIT);
      more_words = (word_cnt_q < WORDS_C);
      word_ready = !abort &&
                   ((state_q == S_LOAD) ||
                    ((state_q == S_SHIFT) && last_bit && more_words));
      accept     = word_valid && word_ready;
   end

   // Next-state and datapath decode for the load sequencer.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_LOAD;
               bit_cnt_d  = '0;
               word_cnt_d = '0;
            end
         end
         S_LOAD: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (accept) begin
               if (parity_ok) begin
                  state_d    = S_SHIFT;
                  shift_d    = word_data;
                  bit_cnt_d  = '0;
                  word_cnt_d = word_cnt_q + WCW'(1);
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_SHIFT: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (last_bit) begin
               if (!more_words) begin
                  state_d = S_DONE;
               end else if (accept) begin
                  if (parity_ok) begin
                     shift_d    = word_data;
                     bit_cnt_d  = '0;
                     word_cnt_d = word_cnt_q + WCW'(1);
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  state_d = S_LOAD;
               end
            end else begin
               shift_d   = shift_q >> 1;
               bit_cnt_d = bit_cnt_q + BCW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs; outputs are decoded from the
   // next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         word_cnt_q  <= '0;
         config_in_q <= 1'b0;
         config_en_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef CFG_LOADER_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         word_cnt_q  <= word_cnt_d;
         config_en_q <= (state_d == S_SHIFT);
         config_in_q <= (state_d == S_SHIFT) && shift_d[0];
         busy_q      <= (state_d == S_LOAD) || (state_d == S_SHIFT);
         done_q      <= (state_d == S_DONE);
`ifdef CFG_LOADER_PARITY_EN
         if ((state_q == S_IDLE) && start) begin
            parity_err_q <= 1'b0;
         end else if (accept && !parity_ok) begin
            parity_err_q <= 1'b1;
         end
`endif
      end
   end

   assign config_in = config_in_q;
   assign config_en = config_en_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_chain_cfg_loader.sv
// ============================================================================
//  Module   : tb_mac_chain_cfg_loader
//  Purpose  : Self-checking bench for mac_chain_cfg_loader (2 clusters x 16
//             bits, 8-bit words). Expected bit streams, shift counts, gap
//             counts and done timing are derived from the word list and the
//             stall plan the bench itself drives.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_chain_cfg_loader;

   localparam int NWORDS = 4;
   localparam int NBITS  = 32;
   localparam int LOGSZ  = 4096;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       abort;
   logic       word_valid;
   logic [7:0] word_data;
   logic       word_ready;
   logic       config_in;
   logic       config_en;
   logic       busy;
   logic       done;
`ifdef CFG_LOADER_PARITY_EN
   logic       word_parity;
   logic       parity_err;
`endif

   mac_chain_cfg_loader #(
      .NUM_CLUSTERS     (2),
      .BITS_PER_CLUSTER (16),
      .WORD_W           (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .word_valid (word_valid),
      .word_data  (word_data),
      .word_ready (word_ready),
      .config_in  (config_in),
      .config_en  (config_en),
      .busy       (busy),
      .done       (done)
`ifdef CFG_LOADER_PARITY_EN
      ,
      .word_parity (word_parity),
      .parity_err  (parity_err)
`endif
   );

   always #5 clk = ~clk;

   // Monitor state: every enabled bit is logged with its cycle number.
   int   cyc = 0;
   int   en_total = 0;
   int   done_total = 0;
   int   done_cyc = -1;
   logic bit_log [LOGSZ];
   int   cyc_log [LOGSZ];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (config_en && en_total < LOGSZ) begin
         bit_log[en_total] <= config_in;
         cyc_log[en_total] <= cyc;
         en_total          <= en_total + 1;
      end
      if (done) begin
         done_total <= done_total + 1;
         done_cyc   <= cyc;
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Stimulus plan for one load: the words and how many ready cycles the
   // source withholds before offering each word.
   logic [7:0] words  [NWORDS];
   int         stalls [NWORDS];

   // Drives one load from start. abort_bit/start_mid give the 0-based bit
   // index (counted on config_en) at which abort or a stray start is raised.
   task automatic run_load(input int abort_bit, input int start_mid,
                           output int en0, output int d0, output int acc0);
      int idx, bits, guard;
      int left [NWORDS];
      bit fin;
      idx = 0; bits = 0; guard = 0; fin = 0; acc0 = -1;
      for (int i = 0; i < NWORDS; i++) left[i] = stalls[i];
      #1;
      en0 = en_total;
      d0  = done_total;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!fin) begin
         if (abort) begin
            abort = 1'b0;
            check_eq("abort_idle", 64'({word_ready, busy, config_en, done}), 64'd0);
            fin = 1;
         end else if (done) begin
            check_eq("busy_at_done", 64'(busy), 64'd0);
            fin = 1;
         end else if (guard > 400) begin
            check_eq("load_timeout", 64'd1, 64'd0);
            fin = 1;
         end else begin
            start = 1'b0;
            if (config_en) begin
               if (bits == abort_bit) abort = 1'b1;
               if (bits == start_mid) start = 1'b1;
               bits++;
            end
            #1;
            if (idx < NWORDS) begin
               word_data = words[idx];
`ifdef CFG_LOADER_PARITY_EN
               word_parity = ^words[idx];
`endif
               if (word_ready && left[idx] > 0) begin
                  word_valid = 1'b0;
                  left[idx]--;
               end else begin
                  word_valid = 1'b1;
                  if (word_ready) begin
                     if (idx == 0) acc0 = cyc;
                     idx++;
                  end
               end
            end else begin
               word_valid = 1'b0;
            end
            @(negedge clk);
            guard++;
         end
      end
      start      = 1'b0;
      word_valid = 1'b0;
   endtask

   // Compares what the chain saw against the plan: bit stream, shift count,
   // first-bit latency, number of done pulses, span with stall gaps, and
   // done placement right after the last bit.
   task automatic check_load(input string tag, input int en0, input int d0,
                             input int acc0, input int nbits, input int ndone);
      logic [63:0] got, exp;
      int gaps;
      got = '0; exp = '0; gaps = 0;
      for (int i = 0; i < NWORDS; i++) exp[8*i +: 8] = words[i];
      for (int i = 1; i < NWORDS; i++) gaps += stalls[i];
      if (nbits < 64) exp = exp & ((64'd1 << nbits) - 64'd1);
      for (int i = 0; i < nbits; i++)
         if (en0 + i < LOGSZ) got[i] = bit_log[en0 + i];
      check_eq({tag, "_en_count"}, 64'(en_total - en0), 64'(nbits));
      check_eq({tag, "_bits"}, got, exp);
      check_eq({tag, "_done_count"}, 64'(done_total - d0), 64'(ndone));
      if (en_total > en0)
         check_eq({tag, "_first_lat"}, 64'(cyc_log[en0]), 64'(acc0 + 1));
      if (ndone == 1 && en_total - en0 == nbits) begin
         check_eq({tag, "_span"}, 64'(cyc_log[en0 + nbits - 1] - cyc_log[en0] + 1),
                  64'(nbits + gaps));
         check_eq({tag, "_done_cyc"}, 64'(done_cyc), 64'(cyc_log[en0 + nbits - 1] + 1));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int en0, d0, acc0, snap;
      rst = 1'b1; start = 1'b1; abort = 1'b0; word_valid = 1'b0; word_data = '0;
`ifdef CFG_LOADER_PARITY_EN
      word_parity = 1'b0;
`endif
      // Reset held with start asserted: everything stays quiet.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("reset_outs", 64'({word_ready, config_en, busy, done, config_in}), 64'd0);
      end
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("ready_after_start", 64'({word_ready, busy}), 64'h3);
      // Reset during LOAD returns to idle.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("reset_midload", 64'({word_ready, busy, config_en}), 64'd0);

      // Gapless load of the reference word set.
      words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h01;
      for (int i = 0; i < NWORDS; i++) stalls[i] = 0;
      @(negedge clk);
      run_load(-1, -1, en0, d0, acc0);
      repeat (3) @(negedge clk);
      #1;
      check_load("gapless", en0, d0, acc0, NBITS, 1);

      // Source stalls for 5 cycles between words 2 and 3.
      stalls[3] = 5;
      @(negedge clk);
      run_load(-1, -1, en0, d0, acc0);
      repeat (3) @(negedge clk);
      #1;
      check_load("stall", en0, d0, acc0, NBITS, 1);
      stalls[3] = 0;

      // Abort on the 3rd bit of word 1: bits 0..10 were shifted, no done.
      @(negedge clk);
      run_load(10, -1, en0, d0, acc0);
      repeat (4) @(negedge clk);
      #1;
      check_load("abort", en0, d0, acc0, 11, 0);

      // After abort a fresh start reloads from word 0 with a full count.
      @(negedge clk);
      run_load(-1, -1, en0, d0, acc0);
      repeat (3) @(negedge clk);
      #1;
      check_load("reload", en0, d0, acc0, NBITS, 1);

      // Abort in LOAD with a word offered: the word is refused.
      @(negedge clk);
      snap = en_total;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b1; word_valid = 1'b1; word_data = 8'h55;
      #1;
      check_eq("abort_load_ready", 64'(word_ready), 64'd0);
      @(negedge clk);
      abort = 1'b0; word_valid = 1'b0;
      check_eq("abort_load_idle", 64'({busy, config_en, word_ready}), 64'd0);
      repeat (3) @(negedge clk);
      #1;
      check_eq("abort_load_noshift", 64'(en_total - snap), 64'd0);

      // Stray start while shifting is ignored.
      @(negedge clk);
      run_load(-1, 5, en0, d0, acc0);
      repeat (3) @(negedge clk);
      #1;
      check_load("start_busy", en0, d0, acc0, NBITS, 1);

      // Randomized words and stall plans.
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < NWORDS; i++) begin
            words[i]  = 8'($urandom);
            stalls[i] = int'($urandom_range(0, 3));
         end
         @(negedge clk);
         run_load(-1, -1, en0, d0, acc0);
         repeat (3) @(negedge clk);
         #1;
         check_load("random", en0, d0, acc0, NBITS, 1);
      end

`ifdef CFG_LOADER_PARITY_EN
      // Bad parity word: not shifted, error flag latched until next start.
      @(negedge clk);
      snap = en_total;
      d0   = done_total;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; word_valid = 1'b1; word_data = 8'h07; word_parity = 1'b0;
      @(negedge clk);
      word_valid = 1'b0;
      check_eq("parity_err_set", 64'({parity_err, busy}), 64'h2);
      repeat (3) @(negedge clk);
      #1;
      check_eq("parity_err_hold", 64'(parity_err), 64'd1);
      check_eq("parity_noshift", 64'(en_total - snap), 64'd0);
      check_eq("parity_nodone", 64'(done_total - d0), 64'd0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("parity_err_clear", 64'(parity_err), 64'd0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
`endif

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
